// File: rtl/rep_umul_acc_if.sv
// Handshake and datapath bundle between rep_umul_acc, its requester and the rep_uMUL it drives.
interface rep_umul_acc_if #(
  parameter int unsigned BITWIDTH = 8
);
  logic                iStart;
  logic [BITWIDTH-1:0] iB;
  logic                iMult;
  logic                iAck;
  logic [BITWIDTH-1:0] oB;
  logic                oLoadB;
  logic                oClr;
  logic                oBusy;
  logic [BITWIDTH-1:0] oResult;
  logic                oValid;

  modport slave (
    input  iStart, iB, iMult, iAck,
    output oB, oLoadB, oClr, oBusy, oResult, oValid
  );

  modport master (
    output iStart, iB, iMult, iAck,
    input  oB, oLoadB, oClr, oBusy, oResult, oValid
  );
endinterface

// File: rtl/rep_umul_acc.sv
// Runs one 2^BITWIDTH-cycle window of a repeated unary multiplier and counts the ones it emits.
module rep_umul_acc #(
  parameter int unsigned BITWIDTH = 8
) (
  input logic             iClk,
  input logic             iRst,
  rep_umul_acc_if.slave   bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]          r_state;
  logic [BITWIDTH:0]   r_acc;
  logic [BITWIDTH-1:0] r_cnt;
  logic [BITWIDTH-1:0] r_b;
  logic                r_load;
  logic                r_clr;
  logic                r_busy;
  logic [BITWIDTH-1:0] r_result;
  logic                r_valid;

  logic [BITWIDTH:0]   w_sum;
  logic                w_cnt_last;

  // iMult feeds the adder directly so the last window bit lands on the DONE edge.
  assign w_sum      = r_acc + {{BITWIDTH{1'b0}}, bus.iMult};
  assign w_cnt_last = (r_cnt == {BITWIDTH{1'b1}});

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_b      <= '0;
      r_load   <= 1'b0;
      r_clr    <= 1'b0;
      r_busy   <= 1'b0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.iStart) begin
            r_b     <= bus.iB;
            r_load  <= 1'b1;
            r_clr   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_load  <= 1'b0;
          r_clr   <= 1'b0;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= RUN;
        end
        RUN: begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + {{(BITWIDTH-1){1'b0}}, 1'b1};
          if (w_cnt_last) begin
            // A full window of ones overflows BITWIDTH bits; clamp to all-ones.
            r_result <= w_sum[BITWIDTH] ? {BITWIDTH{1'b1}} : w_sum[BITWIDTH-1:0];
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= DONE;
          end
        end
        DONE: begin
          if (bus.iAck) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.oB      = r_b;
  assign bus.oLoadB  = r_load;
  assign bus.oClr    = r_clr;
  assign bus.oBusy   = r_busy;
  assign bus.oResult = r_result;
  assign bus.oValid  = r_valid;
endmodule

// File: tb/tb_rep_umul_acc.sv
// Randomized bench for rep_umul_acc against a window-level model, plus literal checks on key cases.
module tb_rep_umul_acc;
  logic iClk;
  logic iRst;
  int   checks;
  int   failures;

  rep_umul_acc_if #(.BITWIDTH(8)) bus ();

  rep_umul_acc #(.BITWIDTH(8)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 window in progress (k = edges since accept), 2 result held.
  int m_mode;
  int m_k;
  int m_ones;
  int m_b;
  int m_res;

  always @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      m_mode <= 0;
      m_k    <= 0;
      m_ones <= 0;
      m_b    <= 0;
      m_res  <= 0;
    end else begin
      case (m_mode)
        0: if (bus.iStart) begin
          m_mode <= 1;
          m_k    <= 0;
          m_ones <= 0;
          m_b    <= 32'(bus.iB);
        end
        1: begin
          m_k <= m_k + 1;
          if (m_k + 1 >= 2) m_ones <= m_ones + 32'(bus.iMult);
          if (m_k + 1 == 257) begin
            m_mode <= 2;
            m_res  <= (m_ones + 32'(bus.iMult) > 255) ? 255 : m_ones + 32'(bus.iMult);
          end
        end
        default: if (bus.iAck) m_mode <= 0;
      endcase
    end
  end

  always @(negedge iClk) begin
    check("oB",      32'(bus.oB),      m_b);
    check("oLoadB",  32'(bus.oLoadB),  (m_mode == 1 && m_k == 0) ? 1 : 0);
    check("oClr",    32'(bus.oClr),    (m_mode == 1 && m_k == 0) ? 1 : 0);
    check("oBusy",   32'(bus.oBusy),   (m_mode == 1) ? 1 : 0);
    check("oValid",  32'(bus.oValid),  (m_mode == 2) ? 1 : 0);
    check("oResult", 32'(bus.oResult), m_res);
  end

  function automatic logic mult_bit(input int mode, input int r);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (r >= 0 && r % 2 == 0);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One full window; exp_res < 0 skips the literal result check.
  task automatic window(input logic [7:0] b, input int mode, input int exp_res,
                        input int ack_wait, input bit poke);
    int cyc;
    int busy_cnt;
    int load_cnt;
    logic [7:0] held;
    @(negedge iClk);
    bus.iStart = 1'b1;
    bus.iB     = b;
    @(negedge iClk);
    bus.iStart = 1'b0;
    bus.iB     = 8'($urandom);
    check("lit_oB_captured", 32'(bus.oB), 32'(b));
    cyc = 0;
    busy_cnt = 0;
    load_cnt = 0;
    while (!bus.oValid && cyc < 400) begin
      if (bus.oBusy) busy_cnt++;
      if (bus.oLoadB) load_cnt++;
      bus.iMult  = mult_bit(mode, cyc - 1);
      bus.iStart = poke && (cyc == 100);
      bus.iB     = 8'($urandom);
      @(negedge iClk);
      cyc++;
    end
    bus.iStart = 1'b0;
    check("lit_latency_edges", cyc, 257);
    check("lit_busy_cycles", busy_cnt, 257);
    check("lit_loadb_cycles", load_cnt, 1);
    if (exp_res >= 0) check("lit_result", 32'(bus.oResult), exp_res);
    held = bus.oResult;
    for (int i = 0; i < ack_wait; i++) begin
      bus.iMult  = 1'($urandom_range(0, 1));
      bus.iStart = poke && (i == 0);
      @(negedge iClk);
      check("lit_valid_held", 32'(bus.oValid), 1);
      check("lit_result_held", 32'(bus.oResult), 32'(held));
    end
    bus.iAck   = 1'b1;
    bus.iStart = poke;
    @(negedge iClk);
    bus.iAck   = 1'b0;
    bus.iStart = 1'b0;
    check("lit_valid_after_ack", 32'(bus.oValid), 0);
    check("lit_busy_after_ack", 32'(bus.oBusy), 0);
    check("lit_oB_stable", 32'(bus.oB), 32'(b));
    @(negedge iClk);
    check("lit_no_restart", 32'(bus.oBusy), 0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    iRst       = 1'b1;
    bus.iStart = 1'b0;
    bus.iB     = '0;
    bus.iMult  = 1'b0;
    bus.iAck   = 1'b0;
    #1;
    check("lit_reset_oValid", 32'(bus.oValid), 0);
    check("lit_reset_oB", 32'(bus.oB), 0);
    #21;
    iRst = 1'b0;

    window(8'h40, 0, 0, 0, 1'b0);
    window(8'h9C, 1, 255, 3, 1'b0);
    window(8'h11, 2, 128, 10, 1'b0);
    window(8'h5A, 3, -1, 2, 1'b1);

    // Reset mid-window abandons it without a result.
    @(negedge iClk);
    bus.iStart = 1'b1;
    bus.iB     = 8'hC3;
    @(negedge iClk);
    bus.iStart = 1'b0;
    for (int i = 0; i < 101; i++) begin
      bus.iMult = 1'b1;
      @(negedge iClk);
    end
    #2 iRst = 1'b1;
    #1;
    check("lit_async_oB", 32'(bus.oB), 0);
    check("lit_async_oBusy", 32'(bus.oBusy), 0);
    check("lit_async_oValid", 32'(bus.oValid), 0);
    check("lit_async_oResult", 32'(bus.oResult), 0);
    repeat (2) @(negedge iClk);
    #2 iRst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge iClk);
      if (bus.oValid) check("lit_no_valid_after_reset", 32'(bus.oValid), 0);
    end

    window(8'h77, 1, 255, 1, 1'b0);
    for (int n = 0; n < 4; n++) begin
      window(8'($urandom), 3, -1, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
